// File: rtl/rgu_pkg.sv
// Shared definitions for the ray-generation microsequencer: opcodes, FSM states
// and instruction field positions derived from the register-file address width.
package rgu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MUL  = 3'd1,
    OP_SUB  = 3'd2,
    OP_ADD  = 3'd3,
    OP_HALF = 3'd4,
    OP_SQRT = 3'd5,
    OP_PUSH = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN,
    ST_SQRT_WAIT,
    ST_FIFO_STALL
  } state_e;

  // Instruction layout, MSB first: {stop, op[2:0], dst, srcA, srcB}
  function automatic int insnWidth(input int rfAddrW);
    return 4 + 3 * rfAddrW;
  endfunction

  function automatic int stopPos(input int rfAddrW);
    return 3 + 3 * rfAddrW;
  endfunction

  function automatic int opLsb(input int rfAddrW);
    return 3 * rfAddrW;
  endfunction

  function automatic int dstLsb(input int rfAddrW);
    return 2 * rfAddrW;
  endfunction

  function automatic int srcALsb(input int rfAddrW);
    return rfAddrW;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgu_isqrt.sv
// Restoring integer square root, one result bit per clock, DATA_W/2 iterations.
// oDone is high for the single cycle in which oRoot holds the final result.
module rgu_isqrt
  import rgu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                iClock,
  input  logic                iReset_n,
  input  logic                iStart,
  input  logic [DATA_W-1:0]   iRadicand,
  output logic                oDone,
  output logic [DATA_W/2-1:0] oRoot
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CNT_W  = $clog2(HALF_W + 1);

  logic [DATA_W-1:0] radReg, srcRad, nRad;
  logic [HALF_W+1:0] remReg, srcRem, nRem, shRem, trial;
  logic [HALF_W-1:0] rootReg, srcRoot, nRoot;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  // The start cycle already performs the first iteration, so the last of
  // DATA_W/2 iterations lands one cycle before the result is consumed.
  always_comb begin
    srcRad  = iStart ? iRadicand : radReg;
    srcRem  = iStart ? '0 : remReg;
    srcRoot = iStart ? '0 : rootReg;
    shRem   = (HALF_W+2)'({srcRem, srcRad[DATA_W-1 -: 2]});
    trial   = {srcRoot, 2'b01};
    nRad    = {srcRad[DATA_W-3:0], 2'b00};
    if (shRem >= trial) begin
      nRem  = shRem - trial;
      nRoot = HALF_W'({srcRoot, 1'b1});
    end else begin
      nRem  = shRem;
      nRoot = HALF_W'({srcRoot, 1'b0});
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      running <= 1'b0;
      cnt     <= '0;
      radReg  <= '0;
      remReg  <= '0;
      rootReg <= '0;
    end else if (iStart) begin
      running <= 1'b1;
      cnt     <= CNT_W'(HALF_W - 1);
      radReg  <= nRad;
      remReg  <= nRem;
      rootReg <= nRoot;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt     <= cnt - 1'b1;
        radReg  <= nRad;
        remReg  <= nRem;
        rootReg <= nRoot;
      end
    end
  end

  assign oDone = running && (cnt == '0);
  assign oRoot = rootReg;

endmodule

// File: rtl/ray_gen_sequencer.sv
// Ray-generation microsequencer: runs a host-loaded fixed-point program over a
// register file and pushes selected results into the downstream ray FIFO.
module ray_gen_sequencer
  import rgu_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int SCALE     = 16,
  parameter  int RF_ADDR_W = 5,
  parameter  int IP_W      = 6,
  parameter  int INSN_W    = insnWidth(RF_ADDR_W),
  localparam int HOST_AW   = maxInt(IP_W, RF_ADDR_W),
  localparam int HOST_DW   = maxInt(DATA_W, INSN_W)
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  output logic               oBusy,
  output logic               oDone,
  input  logic               iFifoFull,
  output logic               oFifoPush,
  output logic [DATA_W-1:0]  oFifoData,
  input  logic               iHostSelect,
  input  logic               iHostWrite,
  input  logic               iHostInsn,
  input  logic [HOST_AW-1:0] iHostAddr,
  input  logic [HOST_DW-1:0] iHostData,
  output logic [HOST_DW-1:0] oHostData
);

  localparam int HALF_W   = DATA_W / 2;
  localparam int STOP_POS = stopPos(RF_ADDR_W);
  localparam int OP_LSB   = opLsb(RF_ADDR_W);
  localparam int DST_LSB  = dstLsb(RF_ADDR_W);
  localparam int SRCA_LSB = srcALsb(RF_ADDR_W);

  logic [INSN_W-1:0] imem [2**IP_W];
  logic [DATA_W-1:0] rf   [2**RF_ADDR_W];

  state_e                  state, stateNext;
  logic [IP_W-1:0]         ip, ipNext, fetchAddr;
  logic [INSN_W-1:0]       insnReg;
  logic                    doneNext, advance, loadInsn, pushNow;
  logic                    sqrtStart, sqrtDone, execWe, hostWe;
  logic [HALF_W-1:0]       sqrtRoot;
  op_e                     op;
  logic                    stopBit;
  logic [RF_ADDR_W-1:0]    dstAddr, srcAAddr, srcBAddr, rfWaddr;
  logic [DATA_W-1:0]       opA, opB, aluRes, execWdata, rfWdata;
  logic                    rfWe;
  logic signed [2*DATA_W-1:0] mulFull;

  assign op       = op_e'(insnReg[OP_LSB +: 3]);
  assign stopBit  = insnReg[STOP_POS];
  assign dstAddr  = insnReg[DST_LSB +: RF_ADDR_W];
  assign srcAAddr = insnReg[SRCA_LSB +: RF_ADDR_W];
  assign srcBAddr = insnReg[0 +: RF_ADDR_W];
  assign opA      = rf[srcAAddr];
  assign opB      = rf[srcBAddr];

  always_comb begin
    mulFull = $signed({{DATA_W{opA[DATA_W-1]}}, opA}) *
              $signed({{DATA_W{opB[DATA_W-1]}}, opB});
    aluRes  = '0;
    case (op)
      OP_MUL:  aluRes = DATA_W'(mulFull >>> SCALE);
      OP_SUB:  aluRes = opA - opB;
      OP_ADD:  aluRes = opA + opB;
      OP_HALF: aluRes = $unsigned($signed(opA) >>> 1);
      default: aluRes = '0;
    endcase
  end

  rgu_isqrt #(.DATA_W(DATA_W)) uIsqrt (
    .iClock    (iClock),
    .iReset_n  (iReset_n),
    .iStart    (sqrtStart),
    .iRadicand (opA),
    .oDone     (sqrtDone),
    .oRoot     (sqrtRoot)
  );

  always_comb begin
    stateNext = state;
    ipNext    = ip;
    doneNext  = 1'b0;
    advance   = 1'b0;
    execWe    = 1'b0;
    execWdata = aluRes;
    pushNow   = 1'b0;
    sqrtStart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          stateNext = ST_FETCH;
          ipNext    = '0;
        end
      end
      ST_FETCH: stateNext = ST_RUN;
      ST_RUN: begin
        case (op)
          OP_MUL, OP_SUB, OP_ADD, OP_HALF: begin
            execWe  = 1'b1;
            advance = 1'b1;
          end
          OP_SQRT: begin
            sqrtStart = 1'b1;
            stateNext = ST_SQRT_WAIT;
          end
          OP_PUSH: begin
            if (!iFifoFull) begin
              pushNow = 1'b1;
              advance = 1'b1;
            end else begin
              stateNext = ST_FIFO_STALL;
            end
          end
          default: advance = 1'b1;
        endcase
      end
      ST_SQRT_WAIT: begin
        if (sqrtDone) begin
          execWe    = 1'b1;
          execWdata = {{(DATA_W-HALF_W){1'b0}}, sqrtRoot};
          advance   = 1'b1;
        end
      end
      ST_FIFO_STALL: begin
        if (!iFifoFull) begin
          pushNow = 1'b1;
          advance = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
    // The last program word ends the run exactly like an explicit stop bit.
    if (advance) begin
      if (stopBit || (ip == '1)) begin
        stateNext = ST_IDLE;
        ipNext    = '0;
        doneNext  = 1'b1;
      end else begin
        stateNext = ST_RUN;
        ipNext    = ip + 1'b1;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= ST_IDLE;
      ip    <= '0;
      oDone <= 1'b0;
    end else begin
      state <= stateNext;
      ip    <= ipNext;
      oDone <= doneNext;
    end
  end

  // Prefetch the next word while executing so a new instruction issues each cycle.
  assign fetchAddr = (state == ST_FETCH) ? ip : ip + 1'b1;
  assign loadInsn  = (state == ST_FETCH) || advance;
  assign hostWe    = (state == ST_IDLE) && iHostSelect && iHostWrite;

  always_ff @(posedge iClock) begin
    if (hostWe && iHostInsn) imem[iHostAddr[IP_W-1:0]] <= iHostData[INSN_W-1:0];
    if (loadInsn) insnReg <= imem[fetchAddr];
  end

  always_comb begin
    rfWe    = execWe;
    rfWaddr = dstAddr;
    rfWdata = execWdata;
    if (hostWe && !iHostInsn) begin
      rfWe    = 1'b1;
      rfWaddr = iHostAddr[RF_ADDR_W-1:0];
      rfWdata = iHostData[DATA_W-1:0];
    end
  end

  always_ff @(posedge iClock) begin
    if (rfWe) rf[rfWaddr] <= rfWdata;
  end

  always_comb begin
    oHostData = '0;
    if (iHostInsn) oHostData[INSN_W-1:0] = imem[iHostAddr[IP_W-1:0]];
    else           oHostData[DATA_W-1:0] = rf[iHostAddr[RF_ADDR_W-1:0]];
  end

  assign oBusy     = state inside {ST_RUN, ST_SQRT_WAIT, ST_FIFO_STALL};
  assign oFifoPush = pushNow;
  assign oFifoData = pushNow ? opA : '0;

endmodule

// File: tb/tb_ray_gen_sequencer.sv
// Self-checking bench for ray_gen_sequencer: ALU vector table, directed
// multi-cycle sequences and random programs against a reference model.
module tb_ray_gen_sequencer;

  logic        clk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iStart = 1'b0;
  logic        oBusy, oDone, oFifoPush;
  logic        iFifoFull = 1'b0;
  logic [31:0] oFifoData;
  logic        iHostSelect = 1'b0, iHostWrite = 1'b0, iHostInsn = 1'b0;
  logic [5:0]  iHostAddr = '0;
  logic [31:0] iHostData = '0;
  logic [31:0] oHostData;

  ray_gen_sequencer dut (
    .iClock(clk), .iReset_n(iReset_n), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
    .iFifoFull(iFifoFull), .oFifoPush(oFifoPush), .oFifoData(oFifoData),
    .iHostSelect(iHostSelect), .iHostWrite(iHostWrite), .iHostInsn(iHostInsn),
    .iHostAddr(iHostAddr), .iHostData(iHostData), .oHostData(oHostData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int doneCount = 0, doneCyc = 0, pushFull = 0, startCyc = 0, doneBase = 0;
  logic [31:0] pushQ[$];
  int pushCycQ[$];

  always @(negedge clk) begin
    if (oFifoPush) begin
      pushQ.push_back(oFifoData);
      pushCycQ.push_back(cyc);
      if (iFifoFull) pushFull++;
    end
    if (oDone) begin
      doneCount++;
      doneCyc = cyc;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hostWr(input bit insn, input int addr, input logic [31:0] data);
    iHostSelect = 1'b1; iHostWrite = 1'b1; iHostInsn = insn;
    iHostAddr = 6'(addr); iHostData = data;
    tick();
    iHostSelect = 1'b0; iHostWrite = 1'b0;
  endtask

  task automatic hostRd(input bit insn, input int addr, output logic [31:0] d);
    iHostInsn = insn; iHostAddr = 6'(addr);
    #1 d = oHostData;
  endtask

  function automatic logic [31:0] mkInsn(input bit stop, input int op, input int d,
                                         input int a, input int b);
    logic [18:0] w;
    w = {stop, 3'(op), 5'(d), 5'(a), 5'(b)};
    return {13'd0, w};
  endfunction

  task automatic startProg();
    doneBase = doneCount;
    pushQ.delete(); pushCycQ.delete();
    startCyc = cyc; iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  // Waits (bounded) for oDone; iFifoFull follows a window or is randomised.
  task automatic waitDone(input int budget, input bit rndFull, input int fullFrom,
                          input int fullLen, output int lat);
    int c;
    for (int n = 0; n < budget && doneCount == doneBase; n++) begin
      c = cyc - startCyc;
      if (rndFull) iFifoFull = ($urandom_range(0, 2) == 0);
      else         iFifoFull = (c >= fullFrom) && (c < fullFrom + fullLen);
      tick();
    end
    iFifoFull = 1'b0;
    check("done_pulse_count", doneCount - doneBase, 1);
    lat = doneCyc - startCyc;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mrf [8];
  int pOp[64], pD[64], pA[64], pB[64];
  logic [31:0] expPush[$];

  function automatic logic [31:0] sqrtRef(input logic [31:0] v);
    longint lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid; else hi = mid - 1;
    end
    return 32'(lo);
  endfunction

  task automatic modelRun(input int len, output int expLat);
    longint p;
    logic [31:0] a, b;
    expPush.delete();
    expLat = 2;
    for (int pc = 0; pc < len; pc++) begin
      a = mrf[pA[pc]]; b = mrf[pB[pc]];
      expLat += (pOp[pc] == 5) ? 17 : 1;
      case (pOp[pc])
        1: begin
          p = longint'($signed(a)) * longint'($signed(b));
          mrf[pD[pc]] = 32'(p >>> 16);
        end
        2: mrf[pD[pc]] = a - b;
        3: mrf[pD[pc]] = a + b;
        4: mrf[pD[pc]] = 32'($signed(a) >>> 1);
        5: mrf[pD[pc]] = sqrtRef(a);
        6: expPush.push_back(a);
        default: ;
      endcase
    end
  endtask

  typedef struct {
    string       name;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] d;
    int lat, expLat, len, nPush;
    bit rnd;

    vecs[0]  = '{"mul_fix",   1, 32'h00020000, 32'h00018000, 32'h00030000, 3};
    vecs[1]  = '{"mul_neg",   1, 32'hFFFE0000, 32'h00018000, 32'hFFFD0000, 3};
    vecs[2]  = '{"mul_trunc", 1, 32'h7FFF0000, 32'h00040000, 32'hFFFC0000, 3};
    vecs[3]  = '{"add_wrap",  3, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3};
    vecs[4]  = '{"sub_wrap",  2, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 3};
    vecs[5]  = '{"half_neg",  4, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFF, 3};
    vecs[6]  = '{"half_min",  4, 32'h80000000, 32'h0,        32'hC0000000, 3};
    vecs[7]  = '{"sqrt_144",  5, 32'd144,      32'h0,        32'd12,       19};
    vecs[8]  = '{"sqrt_max",  5, 32'hFFFFFFFF, 32'h0,        32'h0000FFFF, 19};
    vecs[9]  = '{"sqrt_15",   5, 32'd15,       32'h0,        32'd3,        19};
    vecs[10] = '{"nop",       0, 32'h1,        32'h2,        32'hDEADBEEF, 3};
    vecs[11] = '{"reserved",  7, 32'h1,        32'h2,        32'hDEADBEEF, 3};

    // reset state
    repeat (3) tick();
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_push", oFifoPush, 0);
    check("rst_data", oFifoData, 0);
    iReset_n = 1'b1;
    tick();

    // ALU vector table
    for (int i = 0; i < 12; i++) begin
      hostWr(0, 1, vecs[i].a);
      hostWr(0, 2, vecs[i].b);
      hostWr(0, 3, 32'hDEADBEEF);
      hostWr(1, 0, mkInsn(1, vecs[i].op, 3, 1, 2));
      startProg();
      waitDone(100, 0, 0, 0, lat);
      hostRd(0, 3, d);
      check({vecs[i].name, "_result"}, d, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_busy_after"}, oBusy, 0);
      check({vecs[i].name, "_no_push"}, pushQ.size(), 0);
    end

    // dependent back-to-back adds
    hostWr(0, 1, 32'h11111111);
    hostWr(0, 2, 32'h22222222);
    hostWr(1, 0, mkInsn(0, 3, 3, 1, 2));
    hostWr(1, 1, mkInsn(1, 3, 4, 3, 3));
    startProg();
    waitDone(100, 0, 0, 0, lat);
    hostRd(0, 3, d); check("chain_r3", d, 32'h33333333);
    hostRd(0, 4, d); check("chain_r4", d, 32'h66666666);
    check("chain_latency", lat, 4);

    // sqrt then push
    hostWr(0, 1, 32'd144);
    hostWr(1, 0, mkInsn(0, 5, 2, 1, 0));
    hostWr(1, 1, mkInsn(1, 6, 0, 2, 0));
    startProg();
    waitDone(100, 0, 0, 0, lat);
    check("sqpush_count", pushQ.size(), 1);
    if (pushQ.size() == 1) begin
      check("sqpush_value", pushQ[0], 12);
      check("sqpush_cycle", pushCycQ[0] - startCyc, 19);
    end
    check("sqpush_latency", lat, 20);

    // three pushes, FIFO full for 5 cycles during the second
    hostWr(0, 1, 32'hA1A1A1A1);
    hostWr(0, 2, 32'hB2B2B2B2);
    hostWr(0, 3, 32'hC3C3C3C3);
    hostWr(1, 0, mkInsn(0, 6, 0, 1, 0));
    hostWr(1, 1, mkInsn(0, 6, 0, 2, 0));
    hostWr(1, 2, mkInsn(1, 6, 0, 3, 0));
    startProg();
    waitDone(100, 0, 3, 5, lat);
    check("stall_count", pushQ.size(), 3);
    if (pushQ.size() == 3) begin
      check("stall_v0", pushQ[0], 32'hA1A1A1A1);
      check("stall_v1", pushQ[1], 32'hB2B2B2B2);
      check("stall_v2", pushQ[2], 32'hC3C3C3C3);
      check("stall_c1", pushCycQ[1] - startCyc, 8);
      check("stall_c2", pushCycQ[2] - startCyc, 9);
    end
    check("stall_latency", lat, 10);
    check("stall_push_while_full", pushFull, 0);

    // 64 NOPs without stop; host writes during the run are ignored
    for (int a = 0; a < 64; a++) hostWr(1, a, 32'h0);
    hostWr(0, 5, 32'h00005555);
    startProg();
    repeat (4) tick();
    hostWr(1, 0, mkInsn(1, 6, 1, 1, 1));
    hostWr(0, 5, 32'hCAFEF00D);
    waitDone(200, 0, 0, 0, lat);
    check("nop64_latency", lat, 66);
    repeat (10) tick();
    check("nop64_no_wrap_done", doneCount - doneBase, 1);
    check("nop64_no_push", pushQ.size(), 0);
    check("nop64_busy_after", oBusy, 0);
    hostRd(1, 0, d); check("nop64_imem_kept", d, 0);
    hostRd(0, 5, d); check("nop64_rf_kept", d, 32'h00005555);

    // reset in the middle of the square-root wait, then rerun
    hostWr(0, 1, 32'd144);
    hostWr(0, 2, 32'd0);
    hostWr(1, 0, mkInsn(0, 5, 2, 1, 0));
    hostWr(1, 1, mkInsn(1, 6, 0, 2, 0));
    startProg();
    repeat (8) tick();
    check("midrst_busy_before", oBusy, 1);
    iReset_n = 1'b0;
    #1;
    check("midrst_busy", oBusy, 0);
    check("midrst_push", oFifoPush, 0);
    check("midrst_done", oDone, 0);
    check("midrst_data", oFifoData, 0);
    #3 iReset_n = 1'b1;
    repeat (30) tick();
    check("midrst_no_push", pushQ.size(), 0);
    check("midrst_no_done", doneCount - doneBase, 0);
    hostRd(0, 1, d); check("midrst_rf_kept", d, 144);
    startProg();
    waitDone(100, 0, 0, 0, lat);
    check("rerun_count", pushQ.size(), 1);
    if (pushQ.size() == 1) check("rerun_value", pushQ[0], 12);
    check("rerun_latency", lat, 20);

    // random programs against the reference model
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(2, 12);
      rnd = (it % 2) == 1;
      for (int r = 0; r < 8; r++) begin
        case ($urandom_range(0, 4))
          0: mrf[r] = 32'h7FFFFFFF;
          1: mrf[r] = 32'h80000000;
          2: mrf[r] = 32'hFFFFFFFF;
          default: mrf[r] = $urandom;
        endcase
        hostWr(0, r, mrf[r]);
      end
      for (int pc = 0; pc < len; pc++) begin
        pOp[pc] = $urandom_range(0, 7);
        pD[pc] = $urandom_range(0, 7);
        pA[pc] = $urandom_range(0, 7);
        pB[pc] = $urandom_range(0, 7);
        hostWr(1, pc, mkInsn(pc == len - 1, pOp[pc], pD[pc], pA[pc], pB[pc]));
      end
      modelRun(len, expLat);
      startProg();
      waitDone(3000, rnd, 0, 0, lat);
      if (!rnd) check($sformatf("rnd%0d_latency", it), lat, expLat);
      check($sformatf("rnd%0d_push_count", it), pushQ.size(), expPush.size());
      nPush = (pushQ.size() < expPush.size()) ? pushQ.size() : expPush.size();
      for (int k = 0; k < nPush; k++)
        check($sformatf("rnd%0d_push%0d", it, k), pushQ[k], expPush[k]);
      for (int r = 0; r < 8; r++) begin
        hostRd(0, r, d);
        check($sformatf("rnd%0d_r%0d", it, r), d, mrf[r]);
      end
      tick();
    end
    check("never_push_while_full", pushFull, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ray_gen_sequencer.md
Name: ray_gen_sequencer

Overview:
Parametrised next-generation ray-generation microsequencer. Executes a host-loaded program of fixed-point ALU ops over a register file and pushes results into the downstream ray FIFO. Improvements over the previous generation:
- Generic data width, fixed-point scale and program/register-file depth.
- FIFO back-pressure.
- Multi-cycle iterative square root.
- Explicit start/busy/done control.

Parameters:
DATA_W, 32, datapath and register width (even, >=8)
SCALE, 16, fixed-point fraction bits applied after MUL (< DATA_W)
RF_ADDR_W, 5, register-file address width (2^RF_ADDR_W registers)
IP_W, 6, instruction-pointer width (2^IP_W program words)
INSN_W, 4+3*RF_ADDR_W, instruction width, layout {stop, op[2:0], dst, srcA, srcB}; MSB first

Ports:
iClock  in  1  clock, all state on rising edge
iReset_n  in  1  asynchronous, active-low reset
iStart  in  1  one-cycle start pulse, honoured only in IDLE
oBusy  out  1  high in RUN, SQRT_WAIT, FIFO_STALL
oDone  out  1  one-cycle pulse on program completion
iFifoFull  in  1  downstream FIFO full
oFifoPush  out  1  push strobe
oFifoData  out  DATA_W  pushed value
iHostSelect  in  1  host access enable
iHostWrite  in  1  host write strobe
iHostInsn  in  1  1 = instruction RAM, 0 = register file
iHostAddr  in  max(IP_W,RF_ADDR_W)  host address (low bits used per target)
iHostData  in  max(DATA_W,INSN_W)  host write data (low bits used)
oHostData  out  max(DATA_W,INSN_W)  host read data, zero-extended, combinational from iHostAddr

Behaviour:
Reset:
- All outputs 0.
- IP 0, state IDLE.
- RAM contents are not cleared.

States: IDLE, FETCH, RUN, SQRT_WAIT, FIFO_STALL.

IDLE:
- Host writes go to the selected RAM.
- iStart -> FETCH with IP=0.
- A host write in the same cycle as iStart commits before the fetch.

FETCH:
- Synchronous instruction-RAM read; one cycle.
- -> RUN.

RUN:
- Executes the fetched instruction in one cycle.
- Instruction RAM reads are prefetched on IP+1, so throughput is 1 instruction/cycle.

Register file:
- 2 combinational read ports, 1 write port at the clock edge.
- A dependent next instruction sees the result directly; no forwarding is needed.

Opcodes:
- 0 NOP: no write.
- 1 MUL: signed 2*DATA_W product, arithmetic shift right SCALE, truncated to DATA_W.
- 2 SUB: A-B, modulo 2^DATA_W.
- 3 ADD: A+B, modulo 2^DATA_W.
- 4 HALF: A>>>1 (arithmetic).
- 5 SQRT: floor(sqrt(unsigned A)) via sub-module.
- 6 PUSH: srcA to FIFO; no RF write.
- 7: reserved, executes as NOP.

SQRT:
- RUN -> SQRT_WAIT for DATA_W/2 cycles.
- Result written on the last cycle, then IP advances.
- Total latency is DATA_W/2+1 cycles.

PUSH:
- If iFifoFull=0: oFifoPush=1 and oFifoData=A in the RUN cycle.
- If iFifoFull=1: -> FIFO_STALL.
- FIFO_STALL holds IP and operands, then pushes in the first cycle iFifoFull=0 and resumes.
- A push is never issued while iFifoFull=1.

Termination:
- The stop bit marks the last instruction. It executes normally, including SQRT wait and FIFO stall.
- Then oDone pulses, IP=0, state -> IDLE.
- Executing address 2^IP_W-1 without the stop bit also terminates (no wrap-around).

Host access while busy:
- Writes are ignored.
- Reads of the RF return the current contents.

iStart while busy: ignored.

iReset_n assertion mid-operation, including SQRT_WAIT and FIFO_STALL:
- Immediate return to IDLE.
- No oFifoPush or oDone glitch.

Decomposition:
- Package rgu_pkg: opcode constants, instruction field offset/width functions of RF_ADDR_W, state encoding.
- Sub-module rgu_isqrt: parametrised restoring integer square root; start/done handshake; DATA_W/2 iterations; own async active-low reset.
- RAMs are inferred inline.

Test Plan:
- Host writes R1=0x00020000, R2=0x00018000; program MUL R3,R1,R2 with stop; start -> R3=0x00030000, oDone 3 cycles after iStart, oBusy low afterwards.
- R1=144; SQRT R2,R1; PUSH R2 with stop; iFifoFull=0 -> oFifoData=12 with oFifoPush one cycle after SQRT completes; SQRT_WAIT lasts 16 cycles.
- Three consecutive PUSH with iFifoFull held high 5 cycles during the second -> exactly 3 pushes of the correct values; none while full.
- ADD 0x7FFFFFFF+1 -> 0x80000000; SUB 0-1 -> 0xFFFFFFFF; HALF 0xFFFFFFFE -> 0xFFFFFFFF; dependent back-to-back ADD chain R3=R1+R2, R4=R3+R3 -> correct without stall.
- Program of 64 NOPs with no stop bit -> oDone after address 63, IP=0, no wrap execution; host write during run leaves RAM unchanged.
- Assert iReset_n in the middle of SQRT_WAIT -> outputs 0 immediately; a subsequent iStart reruns the program with identical results.
